// File: rtl/philv_hazard_unit.sv
// philv_hazard_unit: decode-side scoreboard, RAW interlock and forwarding selects; `PHILV_FORWARDING_EN enables bypass selects with load-use stall only
module philv_hazard_unit #(
  parameter int NUM_STAGES     = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int SEL_W          = $clog2(NUM_STAGES+1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     id_valid,
  input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [NUM_READ_PORTS-1:0]                id_rs_used,
  input  logic [REG_ADDR_WIDTH-1:0]                id_rd_addr,
  input  logic                                     id_reg_wr,
  input  logic                                     id_is_load,
  input  logic                                     flush,
  output logic                                     stall,
  output logic                                     issue,
  output logic [NUM_READ_PORTS*SEL_W-1:0]          fwd_sel,
  output logic [NUM_STAGES-1:0]                    stage_valid,
  output logic [2**REG_ADDR_WIDTH-1:0]             busy_regs
);
  logic [NUM_STAGES-1:0]     sb_valid, sb_wr, sb_load;
  logic [REG_ADDR_WIDTH-1:0] sb_rd [NUM_STAGES];
  logic [NUM_READ_PORTS-1:0] hit, load_use;
  logic [NUM_READ_PORTS*SEL_W-1:0] sel;
  logic hazard;
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid <= '0;
      sb_wr    <= '0;
      sb_load  <= '0;
      for (int k = 0; k < NUM_STAGES; k++) sb_rd[k] <= '0;
    end else begin
      sb_valid <= {sb_valid[NUM_STAGES-2:0], issue};
      sb_wr    <= {sb_wr[NUM_STAGES-2:0], issue & id_reg_wr};
      sb_load  <= {sb_load[NUM_STAGES-2:0], issue & id_is_load};
      sb_rd[0] <= issue ? id_rd_addr : '0;
      for (int k = 1; k < NUM_STAGES; k++) sb_rd[k] <= sb_rd[k-1];
    end
  end
  // Oldest to youngest, so the youngest matching entry overwrites the result last
  always_comb begin
    hit      = '0;
    load_use = '0;
    sel      = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++)
      for (int k = NUM_STAGES-1; k >= 0; k--)
        if (id_rs_used[p] && id_rs_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0 &&
            sb_valid[k] && sb_wr[k] && sb_rd[k] == id_rs_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) begin
          hit[p]                 = 1'b1;
          load_use[p]            = (k == 0) && sb_load[k];
          sel[p*SEL_W +: SEL_W]  = SEL_W'(k+1);
        end
  end
  always_comb begin
    busy_regs = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      if (sb_valid[k] && sb_wr[k] && sb_rd[k] != '0) busy_regs[sb_rd[k]] = 1'b1;
  end
`ifdef PHILV_FORWARDING_EN
  assign hazard  = |load_use;
  assign fwd_sel = sel;
  logic unused_hit;
  assign unused_hit = ^hit;
`else
  assign hazard  = |hit;
  assign fwd_sel = '0;
  logic unused_fwd;
  assign unused_fwd = ^{sel, load_use};
`endif
  assign stall       = id_valid & ~flush & hazard;
  assign issue       = id_valid & ~flush & ~stall;
  assign stage_valid = sb_valid;
endmodule

// File: tb/tb_philv_hazard_unit.sv
// tb_philv_hazard_unit: directed cycle-by-cycle vector table plus stall-length sequences; expectations follow `PHILV_FORWARDING_EN
module tb_philv_hazard_unit;
  logic clk = 0, rst = 1, id_valid = 0, id_reg_wr = 0, id_is_load = 0, flush = 0;
  logic [9:0]  id_rs_addr = '0;
  logic [1:0]  id_rs_used = '0;
  logic [4:0]  id_rd_addr = '0;
  logic        stall, issue;
  logic [3:0]  fwd_sel;
  logic [2:0]  stage_valid;
  logic [31:0] busy_regs;
  int n_run = 0, n_fail = 0;

  philv_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_reg_wr(id_reg_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(stall), .issue(issue),
    .fwd_sel(fwd_sel), .stage_valid(stage_valid), .busy_regs(busy_regs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, val;
    logic [4:0] a1, a2;
    logic [1:0] used;
    logic [4:0] rd;
    logic wr, ld, fl;
    logic st, is;
    logic [3:0] fs;
    logic [2:0] sv;
    logic [31:0] busy;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic r, val, input logic [4:0] a1, a2, input logic [1:0] used,
                     input logic [4:0] rd, input logic wr, ld, fl, input logic st, is,
                     input logic [3:0] fs, input logic [2:0] sv, input logic [31:0] busy);
    vec_t v;
    v = '{r, val, a1, a2, used, rd, wr, ld, fl, st, is, fs, sv, busy};
    tv.push_back(v);
  endtask

  task automatic idle(input logic [2:0] sv, input logic [31:0] busy);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sv, busy);
  endtask

  task automatic wrt(input logic [4:0] rd, input logic ld, input logic [2:0] sv, input logic [31:0] busy);
    add(0, 1, 0, 0, 0, rd, 1, ld, 0, 0, 1, 0, sv, busy);
  endtask

  task automatic stall_len(input string name, input logic [4:0] rd, input logic ld,
                           input logic [4:0] rs, input logic port, input int exp);
    int cnt;
    id_valid = 1; id_rs_used = 0; id_rd_addr = rd; id_reg_wr = 1; id_is_load = ld;
    @(posedge clk); #1;
    id_rs_addr = port ? {rs, 5'd0} : {5'd0, rs};
    id_rs_used = port ? 2'b10 : 2'b01;
    id_rd_addr = 5'd20; id_is_load = 0;
    cnt = 0;
    #1;
    while (stall && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_run++;
    if (cnt != exp || !issue) begin
      n_fail++;
      $display("FAIL %s stall_cycles=%0d issue=%b, want stall_cycles=%0d issue=1", name, cnt, issue, exp);
    end
    id_valid = 0; id_rs_used = 0; id_reg_wr = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0);
    // back-to-back RAW on x5
    wrt(5, 0, 3'b000, 32'h0);
`ifdef PHILV_FORWARDING_EN
    add(0, 1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 1, 4'b0001, 3'b001, 32'h20);
    idle(3'b011, 32'h60); idle(3'b110, 32'h60); idle(3'b100, 32'h40);
`else
    add(0, 1, 5, 0, 2'b01, 6, 1, 0, 0, 1, 0, 0, 3'b001, 32'h20);
    add(0, 1, 5, 0, 2'b01, 6, 1, 0, 0, 1, 0, 0, 3'b010, 32'h20);
    add(0, 1, 5, 0, 2'b01, 6, 1, 0, 0, 1, 0, 0, 3'b100, 32'h20);
    add(0, 1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 1, 0, 3'b000, 32'h0);
    idle(3'b001, 32'h40); idle(3'b010, 32'h40); idle(3'b100, 32'h40);
`endif
    // load-use on x7 via port 1
    wrt(7, 1, 3'b000, 32'h0);
`ifdef PHILV_FORWARDING_EN
    add(0, 1, 0, 7, 2'b10, 8, 1, 0, 0, 1, 0, 0, 3'b001, 32'h80);
    add(0, 1, 0, 7, 2'b10, 8, 1, 0, 0, 0, 1, 4'b1000, 3'b010, 32'h80);
    idle(3'b101, 32'h180); idle(3'b010, 32'h100); idle(3'b100, 32'h100);
`else
    add(0, 1, 0, 7, 2'b10, 8, 1, 0, 0, 1, 0, 0, 3'b001, 32'h80);
    add(0, 1, 0, 7, 2'b10, 8, 1, 0, 0, 1, 0, 0, 3'b010, 32'h80);
    add(0, 1, 0, 7, 2'b10, 8, 1, 0, 0, 1, 0, 0, 3'b100, 32'h80);
    add(0, 1, 0, 7, 2'b10, 8, 1, 0, 0, 0, 1, 0, 3'b000, 32'h0);
    idle(3'b001, 32'h100); idle(3'b010, 32'h100); idle(3'b100, 32'h100);
`endif
    // x0 writer never busy; x3 in entries 0 and 2, youngest wins
    wrt(3, 0, 3'b000, 32'h0); wrt(0, 0, 3'b001, 32'h8); wrt(3, 0, 3'b011, 32'h8);
`ifdef PHILV_FORWARDING_EN
    add(0, 1, 0, 3, 2'b11, 9, 1, 0, 0, 0, 1, 4'b0100, 3'b111, 32'h8);
    idle(3'b111, 32'h208); idle(3'b110, 32'h208); idle(3'b100, 32'h200);
`else
    add(0, 1, 0, 3, 2'b11, 9, 1, 0, 0, 1, 0, 0, 3'b111, 32'h8);
    add(0, 1, 0, 3, 2'b11, 9, 1, 0, 0, 1, 0, 0, 3'b110, 32'h8);
    add(0, 1, 0, 3, 2'b11, 9, 1, 0, 0, 1, 0, 0, 3'b100, 32'h8);
    add(0, 1, 0, 3, 2'b11, 9, 1, 0, 0, 0, 1, 0, 3'b000, 32'h0);
    idle(3'b001, 32'h200); idle(3'b010, 32'h200); idle(3'b100, 32'h200);
`endif
    // flush while a hazard is active
    wrt(7, 1, 3'b000, 32'h0);
    add(0, 1, 0, 7, 2'b10, 8, 1, 0, 1, 0, 0, 0, 3'b001, 32'h80);
    idle(3'b010, 32'h80); idle(3'b100, 32'h80);
    // reset mid-stall with three valid entries
    wrt(1, 0, 3'b000, 32'h0); wrt(2, 0, 3'b001, 32'h2); wrt(3, 1, 3'b011, 32'h6);
    add(1, 1, 3, 0, 2'b01, 10, 1, 0, 0, 1, 0, 0, 3'b111, 32'hE);
    add(0, 1, 3, 0, 2'b01, 10, 1, 0, 0, 0, 1, 0, 3'b000, 32'h0);
    idle(3'b001, 32'h400); idle(3'b010, 32'h400); idle(3'b100, 32'h400);

    @(posedge clk); #1;
    for (int i = 0; i < tv.size(); i++) begin
      logic [40:0] got, exp;
      rst = tv[i].r; id_valid = tv[i].val; id_rs_addr = {tv[i].a2, tv[i].a1};
      id_rs_used = tv[i].used; id_rd_addr = tv[i].rd; id_reg_wr = tv[i].wr;
      id_is_load = tv[i].ld; flush = tv[i].fl;
      #2;
      got = {stall, issue, tv[i].is ? fwd_sel : 4'd0, stage_valid, busy_regs};
      exp = {tv[i].st, tv[i].is, tv[i].fs, tv[i].sv, tv[i].busy};
      n_run++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL vec%0d {stall,issue,fwd,sv,busy} got=%h want=%h", i, got, exp);
      end
      @(posedge clk); #1;
    end
    rst = 0; id_valid = 0; flush = 0; id_rs_used = 0; id_reg_wr = 0; id_is_load = 0;
    repeat (3) @(posedge clk);
    #1;
`ifdef PHILV_FORWARDING_EN
    stall_len("raw_stall_len", 5'd5, 1'b0, 5'd5, 1'b0, 0);
    stall_len("load_use_stall_len", 5'd7, 1'b1, 5'd7, 1'b1, 1);
`else
    stall_len("raw_stall_len", 5'd5, 1'b0, 5'd5, 1'b0, 3);
    stall_len("load_use_stall_len", 5'd7, 1'b1, 5'd7, 1'b1, 3);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/philv_hazard_unit.md
Name: philv_hazard_unit

Overview:
- Parametrised pipeline hazard and interlock unit for the Philosophy V core.
- Sits beside the decode stage.
- Tracks in-flight register writers across NUM_STAGES post-decode stages (EX, MEM, WB by default) in an internal scoreboard pipe.
- Generates the front-end stall, the issue strobe and per-read-port forwarding selects.
- Handles decode flush for branches.

Parameters:
- NUM_STAGES, 3, number of post-decode stages tracked; entry 0 = EX, entry NUM_STAGES-1 = final writeback stage.
- REG_ADDR_WIDTH, 5, register address width; register file has 2^REG_ADDR_WIDTH entries.
- NUM_READ_PORTS, 2, number of source operands checked per instruction.
- SEL_W, $clog2(NUM_STAGES+1), width of each forwarding select field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs_addr  in  NUM_READ_PORTS*REG_ADDR_WIDTH  source register addresses; port p occupies bits [p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH].
- id_rs_used  in  NUM_READ_PORTS  bit p set when source p is actually read.
- id_rd_addr  in  REG_ADDR_WIDTH  destination register.
- id_reg_wr  in  1  instruction writes id_rd_addr.
- id_is_load  in  1  result is available only at the end of entry 1 (MEM).
- flush  in  1  kill the instruction currently in decode.
- stall  out  1  hold PC and IF register; combinational.
- issue  out  1  decode instruction advances into entry 0 at the next edge.
- fwd_sel  out  NUM_READ_PORTS*SEL_W  per port: 0 = register file, k = result of entry k-1.
- stage_valid  out  NUM_STAGES  valid bit of each scoreboard entry.
- busy_regs  out  2^REG_ADDR_WIDTH  bitmap of registers with a pending write in any valid entry.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Scoreboard: NUM_STAGES entries, each {valid, rd, wr, load}.
- Entry update at every edge:
  - entry[0] <= issue ? {1, id_rd_addr, id_reg_wr, id_is_load} : bubble (all zero).
  - entry[k] <= entry[k-1] for k ≥ 1.
  - The back end never stalls; stall inserts bubbles only.
- Match rule: entry k matches port p when all hold:
  - id_rs_used[p] = 1
  - rs_p != 0
  - entry[k].valid = 1 and entry[k].wr = 1
  - entry[k].rd = rs_p
- Register x0 never causes a hazard and never appears in busy_regs; a write to x0 gives no match.
- When several entries match, the youngest (lowest k) wins.
- The register file writes on the final-stage edge, so a match in entry NUM_STAGES-1 is still a hazard; there is no same-cycle register file bypass.
- stall = id_valid & ~flush & hazard; issue = id_valid & ~flush & ~stall.
- flush takes priority: stall=0, issue=0, and a bubble enters entry 0. Entries already in flight are not killed.
- Stall and fwd_sel are pure combinational functions of inputs and the scoreboard; zero-cycle latency.
- Reset:
  - All entries are invalid at the next edge; stage_valid=0 and busy_regs=0.
  - With id_valid=0, stall=0, issue=0 and fwd_sel=0.
  - Reset mid-stall discards all pending hazards; the held instruction re-evaluates against an empty scoreboard and issues on the first post-reset cycle if still valid.
- Simultaneous id_reg_wr with rd = rs in the same instruction: no self-hazard; only in-flight entries are compared.

Optional Feature:
- Macro: PHILV_FORWARDING_EN.
- Defined:
  - hazard = any port whose youngest match is entry 0 with load=1 (load-use); one bubble is inserted.
  - Otherwise fwd_sel[p] = k+1 for the youngest matching entry k, else 0.
  - fwd_sel is only meaningful when issue=1.
- Undefined:
  - hazard = any match in any entry.
  - fwd_sel is tied to 0.
  - A back-to-back dependency stalls NUM_STAGES cycles.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, id_valid=0 -> stall=0, issue=0, stage_valid=3'b000, busy_regs=0.
- Back-to-back RAW:
  - Stimulus: add x5 issued, next cycle rs1=x5.
  - Without PHILV_FORWARDING_EN: stall=1 for exactly 3 cycles, then issue=1 with fwd_sel=0.
  - With PHILV_FORWARDING_EN: stall=0, fwd_sel[port0]=1.
- Load-use with PHILV_FORWARDING_EN:
  - Stimulus: load x7, then an instruction reading rs2=x7.
  - Required: stall=1 for 1 cycle, then issue=1 with fwd_sel[port1]=2.
- x0 and youngest priority:
  - Stimulus: writes to x0 and x3 in flight, then an instruction reading rs1=x0, rs2=x3, with x3 written by both entry 0 and entry 2.
  - Required: no stall on x0; with forwarding, fwd_sel port0=0 and port1=1.
- Flush during stall: a hazard is active and flush=1 -> stall=0, issue=0, stage_valid[0]=0 at the next edge.
- Reset mid-operation:
  - Stimulus: 3 valid entries and stall=1, then rst=1 for 1 cycle.
  - Required: stage_valid=0 and busy_regs=0 at the next edge; the held instruction issues on the first cycle after reset.
